// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
package regfile_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [1:0] {
      IDLE,
      DUMP,
      DONE
   } state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register-file bus: read port, write port and dump stream in one bundle.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
);
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] rs_addr;
   logic [ADDR_W-1:0] rt_addr;
   logic [DATA_W-1:0] rsv;
   logic [DATA_W-1:0] rtv;
   logic              rvalid;
   logic              wr_en;
   logic              wr_inhibit;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              dump_start;
   logic              dump_valid;
   logic [ADDR_W-1:0] dump_addr;
   logic [DATA_W-1:0] dump_data;
   logic              done;

   modport master (
      output rd_valid, rs_addr, rt_addr, wr_en, wr_inhibit, wr_addr, wr_data, dump_start,
      input  rd_ready, rsv, rtv, rvalid, dump_valid, dump_addr, dump_data, done
   );

   modport slave (
      input  rd_valid, rs_addr, rt_addr, wr_en, wr_inhibit, wr_addr, wr_data, dump_start,
      output rd_ready, rsv, rtv, rvalid, dump_valid, dump_addr, dump_data, done
   );
endinterface

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: walks every register index once, then parks in DONE.
module regfile_dump_seq
   import regfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              dump_start,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic              done,
   output logic              rd_ready
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      dump_valid = 1'b0;
      done       = 1'b0;
      rd_ready   = 1'b1;
      unique case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (dump_start) begin
               state_d = DUMP;
               cnt_d   = '0;
            end
         end
         DUMP: begin
            dump_valid = 1'b1;
            rd_ready   = 1'b0;
            cnt_d      = cnt_q + 1'b1;
            if (cnt_q == {ADDR_W{1'b1}}) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign dump_addr = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// DATA_W x 2^ADDR_W register file, two registered read ports, one write port, array dump.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to reads and the dump stream.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input logic         clk,
   input logic         rst_n,
   regfile_mp_if.slave bus
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_commit;
   logic [DATA_W-1:0] rs_fwd, rt_fwd, dump_fwd;
   logic [DATA_W-1:0] rs_val, rt_val, dump_val;

   regfile_dump_seq #(.ADDR_W(ADDR_W)) u_dump_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .dump_start (bus.dump_start),
      .dump_valid (bus.dump_valid),
      .dump_addr  (bus.dump_addr),
      .done       (bus.done),
      .rd_ready   (bus.rd_ready)
   );

   assign wr_commit = bus.wr_en && !bus.wr_inhibit && (bus.wr_addr != '0);

`ifdef REGFILE_BYPASS_EN
   assign rs_fwd   = (wr_commit && bus.wr_addr == bus.rs_addr)   ? bus.wr_data : regs[bus.rs_addr];
   assign rt_fwd   = (wr_commit && bus.wr_addr == bus.rt_addr)   ? bus.wr_data : regs[bus.rt_addr];
   assign dump_fwd = (wr_commit && bus.wr_addr == bus.dump_addr) ? bus.wr_data : regs[bus.dump_addr];
`else
   assign rs_fwd   = regs[bus.rs_addr];
   assign rt_fwd   = regs[bus.rt_addr];
   assign dump_fwd = regs[bus.dump_addr];
`endif

   // Register 0 is forced to zero on every read path, independent of array contents.
   assign rs_val   = (bus.rs_addr   == '0) ? '0 : rs_fwd;
   assign rt_val   = (bus.rt_addr   == '0) ? '0 : rt_fwd;
   assign dump_val = (bus.dump_addr == '0) ? '0 : dump_fwd;

   assign bus.dump_data = bus.dump_valid ? dump_val : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the array is reset explicitly because a reset mid-dump must clear every register.
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (wr_commit) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rsv    <= '0;
         bus.rtv    <= '0;
         bus.rvalid <= 1'b0;
      end else begin
         bus.rvalid <= bus.rd_valid && bus.rd_ready;
         if (bus.rd_valid && bus.rd_ready) begin
            bus.rsv <= rs_val;
            bus.rtv <= rt_val;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: vector table for reads/writes plus dump and reset sequences.
module tb_regfile_mp;
   import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_total = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(8), .ADDR_W(5)) bus ();

   regfile_mp #(.DATA_W(8), .ADDR_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic       wr_en;
      logic       wr_inh;
      logic [4:0] wa;
      logic [7:0] wd;
      logic       rv;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       exp_rvalid;
      logic [7:0] exp_rsv;
      logic [7:0] exp_rtv;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.rd_valid   = 1'b0;
      bus.rs_addr    = '0;
      bus.rt_addr    = '0;
      bus.wr_en      = 1'b0;
      bus.wr_inhibit = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.dump_start = 1'b0;
   endtask

   function automatic logic [7:0] dump_exp(input int idx);
      case (idx)
         1:       return 8'h11;
         4:       return 8'h77;
         6:       return BYPASS ? 8'h66 : 8'h00;
         7:       return 8'h3C;
         9:       return 8'h33;
         31:      return 8'hEE;
         default: return 8'h00;
      endcase
   endfunction

   initial begin
      //         we    inh   wa     wd     rv    rs     rt     rvalid rsv                       rtv
      vecs[0]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd3,  5'd0,  1'b1, 8'h00,                    8'h00};
      vecs[1]  = '{1'b1, 1'b0, 5'd4,  8'hA5, 1'b0, 5'd0,  5'd0,  1'b0, 8'h00,                    8'h00};
      vecs[2]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd4,  5'd3,  1'b1, 8'hA5,                    8'h00};
      vecs[3]  = '{1'b1, 1'b0, 5'd7,  8'h3C, 1'b0, 5'd0,  5'd0,  1'b0, 8'hA5,                    8'h00};
      vecs[4]  = '{1'b1, 1'b1, 5'd7,  8'h5A, 1'b0, 5'd0,  5'd0,  1'b0, 8'hA5,                    8'h00};
      vecs[5]  = '{1'b1, 1'b0, 5'd0,  8'hFF, 1'b1, 5'd7,  5'd0,  1'b1, 8'h3C,                    8'h00};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd0,  5'd7,  1'b1, 8'h00,                    8'h3C};
      vecs[7]  = '{1'b1, 1'b0, 5'd9,  8'h33, 1'b1, 5'd9,  5'd4,  1'b1, BYPASS ? 8'h33 : 8'h00,   8'hA5};
      vecs[8]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 5'd9,  5'd9,  1'b1, 8'h33,                    8'h33};
      vecs[9]  = '{1'b1, 1'b1, 5'd9,  8'h44, 1'b1, 5'd1,  5'd9,  1'b1, 8'h00,                    8'h33};
      vecs[10] = '{1'b1, 1'b0, 5'd1,  8'h11, 1'b0, 5'd0,  5'd0,  1'b0, 8'h00,                    8'h33};
      vecs[11] = '{1'b1, 1'b0, 5'd31, 8'hEE, 1'b1, 5'd1,  5'd31, 1'b1, 8'h11,                    BYPASS ? 8'hEE : 8'h00};

      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();

      check("reset rsv", bus.rsv, 0);
      check("reset rtv", bus.rtv, 0);
      check("reset rvalid", bus.rvalid, 0);
      check("reset dump_valid", bus.dump_valid, 0);
      check("reset dump_addr", bus.dump_addr, 0);
      check("reset dump_data", bus.dump_data, 0);
      check("reset done", bus.done, 0);
      check("reset rd_ready", bus.rd_ready, 1);

      foreach (vecs[i]) begin
         bus.wr_en      = vecs[i].wr_en;
         bus.wr_inhibit = vecs[i].wr_inh;
         bus.wr_addr    = vecs[i].wa;
         bus.wr_data    = vecs[i].wd;
         bus.rd_valid   = vecs[i].rv;
         bus.rs_addr    = vecs[i].rs;
         bus.rt_addr    = vecs[i].rt;
         tick();
         check($sformatf("vec%0d rvalid", i), bus.rvalid, vecs[i].exp_rvalid);
         check($sformatf("vec%0d rsv", i), bus.rsv, vecs[i].exp_rsv);
         check($sformatf("vec%0d rtv", i), bus.rtv, vecs[i].exp_rtv);
      end
      idle_inputs();
      tick();
      check("rvalid single pulse", bus.rvalid, 0);

      // Full dump with a read held requesting, a write ahead of the dump pointer and a same-cycle write.
      bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      bus.rd_valid   = 1'b1;
      bus.rs_addr    = 5'd4;
      bus.rt_addr    = 5'd9;
      for (int i = 0; i < 32; i++) begin
         bus.wr_en      = (i == 2) || (i == 6);
         bus.wr_addr    = (i == 2) ? 5'd4 : 5'd6;
         bus.wr_data    = (i == 2) ? 8'h77 : 8'h66;
         bus.dump_start = (i == 5);
         #1;
         check($sformatf("dump%0d valid", i), bus.dump_valid, 1);
         check($sformatf("dump%0d addr", i), bus.dump_addr, i);
         check($sformatf("dump%0d data", i), bus.dump_data, dump_exp(i));
         check($sformatf("dump%0d rd_ready", i), bus.rd_ready, 0);
         check($sformatf("dump%0d done", i), bus.done, 0);
         if (i > 0) check($sformatf("dump%0d rvalid", i), bus.rvalid, 0);
         tick();
      end
      idle_inputs();
      check("after dump valid", bus.dump_valid, 0);
      check("after dump done", bus.done, 1);
      check("after dump rd_ready", bus.rd_ready, 1);
      check("after dump rvalid", bus.rvalid, 0);
      repeat (3) tick();
      check("done sticky", bus.done, 1);

      bus.rd_valid = 1'b1;
      bus.rs_addr  = 5'd6;
      bus.rt_addr  = 5'd4;
      tick();
      bus.rd_valid = 1'b0;
      check("post-dump read r6", bus.rsv, 8'h66);
      check("post-dump read r4", bus.rtv, 8'h77);

      // Restart the dump, then reset while index 10 is on the bus.
      bus.dump_start = 1'b1;
      tick();
      bus.dump_start = 1'b0;
      check("restart clears done", bus.done, 0);
      repeat (10) tick();
      check("pre-reset dump addr", bus.dump_addr, 10);
      check("pre-reset dump valid", bus.dump_valid, 1);
      rst_n = 1'b0;
      #1;
      check("mid-reset dump_valid", bus.dump_valid, 0);
      check("mid-reset done", bus.done, 0);
      check("mid-reset rd_ready", bus.rd_ready, 1);
      check("mid-reset dump_addr", bus.dump_addr, 0);
      check("mid-reset rsv", bus.rsv, 0);
      #2 rst_n = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("post-reset idle%0d dump_valid", i), bus.dump_valid, 0);
         tick();
      end
      for (int i = 0; i < 32; i += 2) begin
         bus.rd_valid = 1'b1;
         bus.rs_addr  = 5'(i);
         bus.rt_addr  = 5'(i + 1);
         tick();
         check($sformatf("cleared r%0d", i), bus.rsv, 0);
         check($sformatf("cleared r%0d", i + 1), bus.rtv, 0);
         check($sformatf("cleared rvalid%0d", i), bus.rvalid, 1);
      end
      idle_inputs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised successor to the processor's 8-bit, 32-entry register file: a DATA_W × 2^ADDR_W register array with two registered read ports, one write port, hardwired-zero register 0, and a sequential dump engine that streams every register out and then raises `done`. It sits between instruction decode (supplies rs/rt/rd) and the ALU/writeback stage. It replaces the single-register output phase with a full-array dump handshake.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W entries
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- rd_valid  in  1  read request; sampled only when rd_ready=1
- rd_ready  out  1  high when not dumping
- rs_addr, rt_addr  in  ADDR_W  read addresses
- rsv, rtv  out  DATA_W  registered read data
- rvalid  out  1  one-cycle pulse: rsv/rtv updated
- wr_en  in  1  write request
- wr_inhibit  in  1  suppresses the write (invalid instruction)
- wr_addr  in  ADDR_W  write address (rd)
- wr_data  in  DATA_W  write data (result)
- dump_start  in  1  start full-array dump
- dump_valid  out  1  dump_addr/dump_data valid this cycle
- dump_addr  out  ADDR_W  index being dumped
- dump_data  out  DATA_W  contents of dump_addr
- done  out  1  sticky: dump completed

## Operation
- FSM states: IDLE, DUMP, DONE.
- IDLE/DONE: reads and writes serviced; rd_ready=1.
- IDLE or DONE with dump_start=1 → DUMP; counter=0; done cleared.
- DUMP: each cycle, dump_valid=1, dump_addr=counter, dump_data=reg[counter]; counter increments. Counter at DEPTH-1 → DONE, done=1 on that edge. dump_start ignored in DUMP.
- DONE holds done=1 until the next dump_start or reset.
- Read: on rd_valid && rd_ready, rsv=reg[rs_addr], rtv=reg[rt_addr], rvalid=1 for exactly one cycle; otherwise rsv/rtv hold and rvalid=0.
- Write: wr_en && !wr_inhibit && wr_addr!=0 → reg[wr_addr]=wr_data. Writes are accepted in every state, including DUMP.
- Register 0 always reads 0 (read ports and dump); writes to it are dropped.
- Reset mid-dump: the FSM returns to IDLE immediately; all registers clear; no further dump_valid pulses.

## Timing
- Reset values: all registers 0, rsv=0, rtv=0, rvalid=0, dump_valid=0, dump_addr=0, dump_data=0, done=0, state IDLE; rd_ready=1.
- Read latency 1: request sampled at edge k; data and rvalid visible after edge k.
- Write commits at the sampling edge; a read issued the following cycle sees the new value.
- Dump: the first dump_valid appears the cycle after dump_start is sampled. DEPTH consecutive dump_valid cycles follow. done rises together with the last dump_valid falling (edge after index DEPTH-1).
- rd_ready is combinational from state: it goes 0 the cycle after dump_start is sampled and returns to 1 in DONE.
- A same-cycle write and dump of the same index is governed by the bypass option (below).

## Configuration
- REGFILE_BYPASS_EN defined: a same-cycle write to the address being read (rs, rt or dump index) forwards wr_data, so the read returns the new value. Register 0 is still forced to 0.
- Undefined: same-cycle reads return the pre-write value; the new value is visible from the next cycle.

## Structure
- Shared package regfile_pkg: state enum type (IDLE, DUMP, DONE), default DATA_W/ADDR_W constants.
- Sub-module regfile_dump_seq: FSM, dump counter, dump_valid/dump_addr/done generation. The top level holds the array, read ports, write logic and bypass mux.

## Test plan
- Reset, then read rs=3/rt=0 → rvalid pulse, rsv=0, rtv=0; done=0, rd_ready=1.
- Write 0xA5 to r4, then read r4 next cycle → rsv=0xA5 after one edge.
- Write 0x5A with wr_inhibit=1, and write 0xFF to r0 → r7 keeps its prior value; r0 reads 0.
- Same-cycle write r9=0x33 and read r9 → 0x33 with REGFILE_BYPASS_EN, old value without it.
- Dump after writing r1=0x11 and r31=0xEE (defaults) → 32 dump_valid cycles with addr 0..31 and matching data; done=1 after the last; rd_valid ignored during the dump.
- Assert rst_n low at dump index 10 → dump_valid=0 immediately, done=0, all registers 0, state IDLE.
